crc_job_ctrl: RTL and testbench
===============================

// Module: crc_job_ctrl
// PURPOSE
//  Bus-master sequencer for the CRC block's simple register bus (addr/data_wr/RW/Sel/data_rd).
//  Accepts one CRC job (poly, seed, word count) and then streams the data words.
//  Programs the CRC block, writes the words, reads back the result and returns it on a result handshake.
//  Sits between the job requester and the crc_if dp-side device; it is the only master on that bus.
// PARAMETERS
//  LEN_W      16     width of job_len (max words per job = 2**LEN_W-1)
//  RD_LAT     1      cycles from read cycle (Sel=1,RW=0) to data_rd valid; legal range 1..3
//  DATA_ADDR  32'h0  CRC data-in register address (write)
//  SEED_ADDR  32'h4  CRC seed register address (write)
//  POLY_ADDR  32'h8  CRC polynomial register address (write)
//  CTRL_ADDR  32'hC  CRC control register; writing 1 re-initialises CRC from seed
//  RES_ADDR   32'h0  CRC result register address (read)
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      reset, asynchronous, active-low
//  job_valid  in   1      job request
//  job_ready  out  1      controller idle, job accepted on valid&ready
//  job_poly   in   32     polynomial for this job
//  job_seed   in   32     initial CRC value
//  job_len    in   LEN_W  number of data words (0 legal)
//  din_valid  in   1      data word available
//  din_ready  out  1      controller takes word on valid&ready
//  din_data   in   32     data word
//  res_valid  out  1      result available
//  res_ready  in   1      result consumed on valid&ready
//  res_crc    out  32     CRC result
//  abort      in   1      synchronous job cancel
//  busy       out  1      high in every state except IDLE
//  addr       out  32     CRC bus address
//  data_wr    out  32     CRC bus write data
//  RW         out  1      0=read 1=write
//  Sel        out  1      CRC device select, one transfer per cycle it is high
//  data_rd    in   32     CRC bus read data
// BEHAVIOUR
//  Reset: job_ready=1, din_ready=0, res_valid=0, res_crc=0, busy=0, Sel=0, RW=0, addr=0, data_wr=0; state IDLE.
//  Bus outputs are registered. When Sel=0, addr, data_wr and RW are all driven 0.
//  FSM: IDLE -> WR_POLY -> WR_SEED -> WR_CTRL -> DATA -> RD_REQ -> RD_WAIT -> DONE -> IDLE.
//  Job accepted in cycle T (IDLE, job_valid=1); poly, seed and len are latched.
//  Bus writes: T+1 POLY_ADDR=poly, T+2 SEED_ADDR=seed, T+3 CTRL_ADDR=1.
//  DATA state: din_ready=1 while remaining>0. A word accepted in cycle k is written to DATA_ADDR in cycle k+1.
//  din_valid gaps produce Sel=0 cycles. Back-to-back words give a back-to-back bus.
//  Last word accepted in L: write at L+1, read (RES_ADDR, RW=0, Sel=1) at L+2.
//  data_rd is sampled at L+2+RD_LAT into res_crc; res_valid=1 from L+3+RD_LAT.
//  job_len=0: DATA is skipped; the read is issued at T+4, after the CTRL write.
//  DONE: res_valid and res_crc are held until res_ready=1; then IDLE next cycle, res_valid=0.
//  job_ready=1 only in IDLE. A new job cannot be accepted in the same cycle the result is consumed.
//  Remaining-word counter is LEN_W wide, loaded with job_len, decremented per din handshake. It never underflows.
//  abort=1 in any non-IDLE state: next cycle IDLE, Sel=0, res_valid=0, counter cleared.
//  A din or res handshake in the abort cycle is discarded. abort in IDLE is ignored.
//  res_crc is not cleared by abort.
//  Asynchronous reset mid-job: all outputs return to reset values immediately. The CRC device state is then undefined.
// STRUCTURE
//  Package crc_ctrl_pkg holds:
//   - state enum crc_ctrl_state_e
//   - default register address localparams
//   - CTRL_INIT = 32'h1
//  Single module, no sub-module: one FSM, one LEN_W counter and one RD_LAT counter (2 bits).
// TESTING
//  1. poly=04C11DB7, seed=FFFFFFFF, len=3, words 1,2,3 back-to-back.
//     -> Bus writes POLY, SEED, CTRL=1, DATA 1, 2, 3, then one read.
//     -> res_crc equals the model data_rd; res_valid at L+3+RD_LAT.
//  2. len=0 -> writes POLY, SEED, CTRL, read at T+4; din_ready never asserted.
//  3. len=4 with din_valid toggling 1,0,1,0 -> Sel=0 in the gap cycles; exactly 4 DATA writes.
//  4. res_ready held 0 for 10 cycles -> res_valid and res_crc stable; job_ready=0 throughout.
//  5. abort asserted during the second DATA write -> IDLE next cycle, Sel=0.
//     -> A following job runs a full, correct sequence.
//  6. rst low mid-DATA -> all outputs at reset values without waiting for a clk edge.
//  7. Sweep RD_LAT=1..3 -> capture cycle and res_valid timing shift by exactly one cycle each step.

Source files
------------

// File: rtl/crc_ctrl_pkg.sv
// Shared types and default register map for the CRC job controller.
// The register offsets match the crc_if device as seen from the data-path side.
package crc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_POLY,
    ST_WR_SEED,
    ST_WR_CTRL,
    ST_DATA,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DONE
  } crc_ctrl_state_e;

  localparam logic [31:0] DEF_DATA_ADDR = 32'h0;
  localparam logic [31:0] DEF_SEED_ADDR = 32'h4;
  localparam logic [31:0] DEF_POLY_ADDR = 32'h8;
  localparam logic [31:0] DEF_CTRL_ADDR = 32'hC;
  localparam logic [31:0] DEF_RES_ADDR  = 32'h0;
  localparam logic [31:0] CTRL_INIT     = 32'h1;

endpackage

// File: rtl/crc_job_ctrl.sv
// Bus-master sequencer: programs the CRC device for one job, streams the data
// words into it, reads the result back and offers it on the result handshake.
module crc_job_ctrl
  import crc_ctrl_pkg::*;
#(
  parameter int          LEN_W     = 16,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] DATA_ADDR = DEF_DATA_ADDR,
  parameter logic [31:0] SEED_ADDR = DEF_SEED_ADDR,
  parameter logic [31:0] POLY_ADDR = DEF_POLY_ADDR,
  parameter logic [31:0] CTRL_ADDR = DEF_CTRL_ADDR,
  parameter logic [31:0] RES_ADDR  = DEF_RES_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_poly,
  input  logic [31:0]      job_seed,
  input  logic [LEN_W-1:0] job_len,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [31:0]      din_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_crc,
  input  logic             abort,
  output logic             busy,
  output logic [31:0]      addr,
  output logic [31:0]      data_wr,
  output logic             RW,
  output logic             Sel,
  input  logic [31:0]      data_rd
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both
  // high at the rising clock edge; ready never depends on valid combinationally.

  localparam logic [1:0] RD_CNT_INIT = 2'(RD_LAT - 1);

  crc_ctrl_state_e  state;
  logic [LEN_W-1:0] remaining;
  logic [1:0]       rd_cnt;
  logic [31:0]      seed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      rd_cnt    <= '0;
      seed_q    <= '0;
      job_ready <= 1'b1;
      din_ready <= 1'b0;
      res_valid <= 1'b0;
      res_crc   <= '0;
      busy      <= 1'b0;
      Sel       <= 1'b0;
      RW        <= 1'b0;
      addr      <= '0;
      data_wr   <= '0;
    end else begin
      // Bus is idle (all zero) unless a state below issues a transfer.
      Sel     <= 1'b0;
      RW      <= 1'b0;
      addr    <= '0;
      data_wr <= '0;
      if (abort && state != ST_IDLE) begin
        state     <= ST_IDLE;
        remaining <= '0;
        rd_cnt    <= '0;
        job_ready <= 1'b1;
        din_ready <= 1'b0;
        res_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (job_valid) begin
              seed_q    <= job_seed;
              remaining <= job_len;
              Sel       <= 1'b1;
              RW        <= 1'b1;
              addr      <= POLY_ADDR;
              data_wr   <= job_poly;
              job_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= ST_WR_POLY;
            end
          end
          ST_WR_POLY: begin
            Sel     <= 1'b1;
            RW      <= 1'b1;
            addr    <= SEED_ADDR;
            data_wr <= seed_q;
            state   <= ST_WR_SEED;
          end
          ST_WR_SEED: begin
            Sel     <= 1'b1;
            RW      <= 1'b1;
            addr    <= CTRL_ADDR;
            data_wr <= CTRL_INIT;
            state   <= ST_WR_CTRL;
          end
          ST_WR_CTRL: begin
            if (remaining == '0) begin
              Sel   <= 1'b1;
              addr  <= RES_ADDR;
              state <= ST_RD_REQ;
            end else begin
              din_ready <= 1'b1;
              state     <= ST_DATA;
            end
          end
          ST_DATA: begin
            // The cycle after the last word's handshake carries its bus write;
            // the result read follows once the counter has reached zero.
            if (remaining == '0) begin
              Sel   <= 1'b1;
              addr  <= RES_ADDR;
              state <= ST_RD_REQ;
            end else if (din_valid && din_ready) begin
              Sel       <= 1'b1;
              RW        <= 1'b1;
              addr      <= DATA_ADDR;
              data_wr   <= din_data;
              remaining <= remaining - 1'b1;
              if (remaining == LEN_W'(1)) din_ready <= 1'b0;
            end
          end
          ST_RD_REQ: begin
            rd_cnt <= RD_CNT_INIT;
            state  <= ST_RD_WAIT;
          end
          ST_RD_WAIT: begin
            if (rd_cnt == 2'd0) begin
              res_crc   <= data_rd;
              res_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              rd_cnt <= rd_cnt - 2'd1;
            end
          end
          ST_DONE: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              job_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crc_job_ctrl.sv
// Bench for crc_job_ctrl: three instances (RD_LAT 1..3), each with a small
// behavioural CRC device on its bus, checked against a job-level reference.
module tb_crc_job_ctrl;

  localparam int NI = 3;
  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_SEED = 32'h4;
  localparam logic [31:0] A_POLY = 32'h8;
  localparam logic [31:0] A_CTRL = 32'hC;
  localparam logic [31:0] A_RES  = 32'h0;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        job_valid [NI];
  logic        job_ready [NI];
  logic [31:0] job_poly  [NI];
  logic [31:0] job_seed  [NI];
  logic [15:0] job_len   [NI];
  logic        din_valid [NI];
  logic        din_ready [NI];
  logic [31:0] din_data  [NI];
  logic        res_valid [NI];
  logic        res_ready [NI];
  logic [31:0] res_crc   [NI];
  logic        abort     [NI];
  logic        busy      [NI];
  logic [31:0] addr      [NI];
  logic [31:0] data_wr   [NI];
  logic        RW        [NI];
  logic        Sel       [NI];
  logic [31:0] data_rd   [NI];

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] poly,
                                           input logic [31:0] d);
    logic [31:0] c;
    c = crc;
    for (int b = 31; b >= 0; b--) begin
      if (c[31] ^ d[b]) c = (c << 1) ^ poly;
      else c = c << 1;
    end
    return c;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    crc_job_ctrl #(.LEN_W(16), .RD_LAT(gi + 1)) u_dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid[gi]), .job_ready(job_ready[gi]),
      .job_poly(job_poly[gi]), .job_seed(job_seed[gi]), .job_len(job_len[gi]),
      .din_valid(din_valid[gi]), .din_ready(din_ready[gi]), .din_data(din_data[gi]),
      .res_valid(res_valid[gi]), .res_ready(res_ready[gi]), .res_crc(res_crc[gi]),
      .abort(abort[gi]), .busy(busy[gi]),
      .addr(addr[gi]), .data_wr(data_wr[gi]), .RW(RW[gi]), .Sel(Sel[gi]),
      .data_rd(data_rd[gi])
    );

    // Behavioural CRC device; read data is valid only RD_LAT cycles after the read.
    logic [31:0] d_poly = 32'h0;
    logic [31:0] d_seed = 32'h0;
    logic [31:0] d_crc  = 32'h0;
    logic [31:0] pv  [4];
    logic        pok [4];
    initial for (int k = 0; k < 4; k++) begin pv[k] = 32'h0; pok[k] = 1'b0; end
    always @(posedge clk) begin
      if (Sel[gi] && RW[gi]) begin
        if (addr[gi] == A_POLY) d_poly <= data_wr[gi];
        else if (addr[gi] == A_SEED) d_seed <= data_wr[gi];
        else if (addr[gi] == A_CTRL && data_wr[gi] == 32'h1) d_crc <= d_seed;
        else if (addr[gi] == A_DATA) d_crc <= crc_step(d_crc, d_poly, data_wr[gi]);
      end
      pok[0] <= Sel[gi] && !RW[gi] && addr[gi] == A_RES;
      pv[0]  <= d_crc;
      for (int k = 1; k < 4; k++) begin
        pok[k] <= pok[k-1];
        pv[k]  <= pv[k-1];
      end
    end
    assign data_rd[gi] = pok[gi] ? pv[gi] : GARBAGE;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cur = 0;
  int idle_err = 0;
  int last_off = 0;
  logic [96:0] exp_q[$];
  logic [96:0] act_q[$];
  logic [31:0] words[$];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (inst %0d, cycle %0d)", tag, act, exp, cur, cyc);
    end
  endtask

  function automatic logic [96:0] txn(input int c, input logic rw, input logic [31:0] a,
                                      input logic [31:0] d);
    return {32'(c), rw, a, d};
  endfunction

  always @(negedge clk) begin
    if (Sel[cur]) act_q.push_back(txn(cyc, RW[cur], addr[cur], data_wr[cur]));
    else if (RW[cur] || addr[cur] != 32'h0 || data_wr[cur] != 32'h0) idle_err++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_words(input int len);
    words.delete();
    for (int i = 0; i < len; i++) words.push_back($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!job_ready[cur] && guard < 50) begin step(); guard++; end
    check("job_ready_wait", job_ready[cur], 1'b1);
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle after each accepted word, 2 random
  task automatic run_job(input logic [31:0] poly, input logic [31:0] seed, input int len,
                         input int gap_mode, input int hold, input bit abort_idle);
    int t, n, guard, rd, rv_cyc, lat;
    int acc[$];
    bit dr_seen, last_acc, stable, v;
    logic [31:0] exp_crc;
    lat = cur + 1;
    wait_idle();
    act_q.delete();
    exp_q.delete();
    idle_err = 0;
    job_valid[cur] = 1'b1;
    job_poly[cur]  = poly;
    job_seed[cur]  = seed;
    job_len[cur]   = 16'(len);
    abort[cur]     = abort_idle;
    t = cyc;
    step();
    job_valid[cur] = 1'b0;
    abort[cur]     = 1'b0;
    check("accept_busy", {busy[cur], job_ready[cur]}, 2'b10);

    n = 0; guard = 0; dr_seen = 1'b0; last_acc = 1'b0;
    while (n < len && guard < 500) begin
      if (gap_mode == 1) v = !last_acc;
      else if (gap_mode == 2) v = 1'($urandom_range(0, 1));
      else v = 1'b1;
      din_valid[cur] = v;
      din_data[cur]  = words[n];
      last_acc = v && din_ready[cur];
      if (last_acc) begin acc.push_back(cyc); n++; end
      step();
      guard++;
    end
    din_valid[cur] = 1'b0;
    check("din_words_taken", n, len);

    guard = 0;
    while (!res_valid[cur] && guard < 100) begin
      if (din_ready[cur]) dr_seen = 1'b1;
      step();
      guard++;
    end
    check("res_valid_seen", res_valid[cur], 1'b1);
    rv_cyc = cyc;
    if (len == 0) check("len0_no_din_ready", dr_seen, 1'b0);

    exp_crc = seed;
    for (int i = 0; i < len; i++) exp_crc = crc_step(exp_crc, poly, words[i]);
    exp_q.push_back(txn(t + 1, 1'b1, A_POLY, poly));
    exp_q.push_back(txn(t + 2, 1'b1, A_SEED, seed));
    exp_q.push_back(txn(t + 3, 1'b1, A_CTRL, 32'h1));
    for (int i = 0; i < acc.size(); i++) exp_q.push_back(txn(acc[i] + 1, 1'b1, A_DATA, words[i]));
    rd = (len == 0 || acc.size() == 0) ? t + 4 : acc[acc.size()-1] + 2;
    exp_q.push_back(txn(rd, 1'b0, A_RES, 32'h0));
    check("res_valid_cycle", rv_cyc, rd + 1 + lat);
    check("res_crc", res_crc[cur], exp_crc);
    last_off = rv_cyc - t;

    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (res_valid[cur] !== 1'b1 || res_crc[cur] !== exp_crc || job_ready[cur] !== 1'b0)
        stable = 1'b0;
      step();
    end
    if (hold > 0) check("res_hold_stable", stable, 1'b1);
    res_ready[cur] = 1'b1;
    step();
    res_ready[cur] = 1'b0;
    check("after_consume", {res_valid[cur], job_ready[cur], busy[cur]}, 3'b010);

    check("bus_txn_count", act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) check("bus_txn", act_q[i], exp_q[i]);
    check("bus_idle_zero", idle_err, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check(tag, {job_ready[cur], din_ready[cur], res_valid[cur], res_crc[cur], busy[cur],
                Sel[cur], RW[cur], addr[cur], data_wr[cur]},
          {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int dw, n, guard, off[NI];
    bit fired;
    for (int i = 0; i < NI; i++) begin
      job_valid[i] = 1'b0; job_poly[i] = '0; job_seed[i] = '0; job_len[i] = '0;
      din_valid[i] = 1'b0; din_data[i] = '0; res_ready[i] = 1'b0; abort[i] = 1'b0;
    end
    #2 rst = 1'b0;
    #1 check_reset_values("reset_values");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    step();

    // basic job, three words back-to-back
    words.delete();
    words.push_back(32'h1); words.push_back(32'h2); words.push_back(32'h3);
    run_job(32'h04C11DB7, 32'hFFFFFFFF, 3, 0, 0, 1'b0);
    // empty job; abort in IDLE during acceptance must be ignored
    run_job(32'h04C11DB7, 32'h12345678, 0, 0, 0, 1'b1);
    // alternating din_valid gaps
    fill_words(4);
    run_job(32'h1EDC6F41, 32'h0, 4, 1, 0, 1'b0);
    // result held back for 10 cycles
    fill_words(2);
    run_job(32'h04C11DB7, 32'hA5A5A5A5, 2, 0, 10, 1'b0);

    // abort during the second DATA write
    fill_words(4);
    wait_idle();
    job_valid[0] = 1'b1; job_poly[0] = 32'h04C11DB7; job_seed[0] = 32'hFFFFFFFF; job_len[0] = 16'd4;
    step();
    job_valid[0] = 1'b0;
    dw = 0; n = 0; guard = 0; fired = 1'b0;
    while (!fired && guard < 40) begin
      if (Sel[0] && RW[0] && addr[0] == A_DATA) dw++;
      din_valid[0] = 1'b1;
      din_data[0]  = words[n];
      if (dw == 2) begin
        abort[0] = 1'b1;
        fired = 1'b1;
      end else if (din_ready[0] && n < 3) begin
        n++;
      end
      step();
      guard++;
    end
    abort[0] = 1'b0;
    din_valid[0] = 1'b0;
    check("abort_reached", fired, 1'b1);
    check("abort_state", {Sel[0], job_ready[0], busy[0], din_ready[0], res_valid[0]}, 5'b01000);
    fill_words(3);
    run_job(32'h04C11DB7, 32'hFFFFFFFF, 3, 0, 2, 1'b0);

    // asynchronous reset in the middle of DATA
    fill_words(4);
    wait_idle();
    job_valid[0] = 1'b1; job_poly[0] = 32'h04C11DB7; job_seed[0] = 32'h1; job_len[0] = 16'd4;
    step();
    job_valid[0] = 1'b0;
    repeat (4) step();
    din_valid[0] = 1'b1; din_data[0] = words[0];
    step();
    din_data[0] = words[1];
    step();
    din_valid[0] = 1'b0;
    check("pre_reset_busy", busy[0], 1'b1);
    #2 rst = 1'b0;
    #1 check_reset_values("async_reset_values");
    @(posedge clk);
    #2 rst = 1'b1;
    step();
    fill_words(2);
    run_job(32'h04C11DB7, 32'hFFFFFFFF, 2, 0, 0, 1'b0);

    // read latency sweep: same job on RD_LAT 1, 2, 3
    for (int i = 0; i < NI; i++) begin
      cur = i;
      words.delete();
      words.push_back(32'hCAFEF00D); words.push_back(32'h00C0FFEE);
      run_job(32'h04C11DB7, 32'hFFFFFFFF, 2, 0, 0, 1'b0);
      off[i] = last_off;
    end
    check("lat_step_1_2", off[1] - off[0], 1);
    check("lat_step_2_3", off[2] - off[1], 1);

    // randomized jobs across all instances
    for (int j = 0; j < 12; j++) begin
      int len;
      cur = j % NI;
      len = $urandom_range(0, 6);
      fill_words(len);
      run_job($urandom, $urandom, len, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
